// File: rtl/foc_pkg.sv
// Shared types and helpers for the FOC sample sequencer and its tick generator.
package foc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitTick,
    StIssue,
    StWaitReady,
    StError
  } seq_state_t;

  localparam int unsigned DefDWidth = 19;
  localparam int unsigned QBits     = 15;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/foc_tick_gen.sv
// Sample-period tick generator: counts while busy, pulses tick on the last count of each period.
module foc_tick_gen #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              busy_i,
  input  logic [TICK_W-1:0] period_i,
  output logic              tick_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d, last;

  always_comb begin
    // A zero period behaves like a period of one: tick every cycle.
    last   = (period_i == '0) ? '0 : period_i - TICK_W'(1);
    tick_o = busy_i && (cnt_q >= last);
    cnt_d  = cnt_q + TICK_W'(1);
    if (!busy_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/foc_sample_sequencer.sv
// Loads PID coefficient tables into the FOC core, then issues one sensor sample per PWM tick
// over valid/ready with overrun counting and a sticky ready timeout.
module foc_sample_sequencer
  import foc_pkg::*;
#(
  parameter int unsigned D_WIDTH        = DefDWidth,
  parameter int unsigned N_COEF         = 2,
  parameter int unsigned VALID_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TICK_W         = 16,
  localparam int unsigned AW            = idx_width(N_COEF)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [TICK_W-1:0]  tick_period,
  input  logic               cfg_wen,
  input  logic               cfg_axis,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  input  logic [D_WIDTH-1:0] angle_in,
  input  logic [D_WIDTH-1:0] currA_in,
  input  logic [D_WIDTH-1:0] currB_in,
  input  logic [D_WIDTH-1:0] currC_in,
  input  logic [D_WIDTH-1:0] currT_in,
  input  logic               core_ready,
  output logic [D_WIDTH-1:0] angle_out,
  output logic [D_WIDTH-1:0] currA_out,
  output logic [D_WIDTH-1:0] currB_out,
  output logic [D_WIDTH-1:0] currC_out,
  output logic [D_WIDTH-1:0] currT_out,
  output logic               core_valid,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_d_addr,
  output logic [D_WIDTH-1:0] pid_q_addr,
  output logic [D_WIDTH-1:0] pid_d_data,
  output logic [D_WIDTH-1:0] pid_q_data,
  output logic               busy,
  output logic               err_timeout,
  output logic [15:0]        overrun_cnt,
  output logic [15:0]        sample_cnt
);

  localparam int unsigned Entries = 2 ** AW;
  localparam int unsigned VcntW   = idx_width(VALID_CYCLES);
  localparam int unsigned ToW     = idx_width(TIMEOUT_CYCLES);
  localparam logic [AW-1:0]    LoadLast = AW'(N_COEF - 1);
  localparam logic [VcntW-1:0] VcntLast = VcntW'(VALID_CYCLES - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

  seq_state_t         state_q;
  logic [D_WIDTH-1:0] dtab_q [Entries];
  logic [D_WIDTH-1:0] qtab_q [Entries];
  logic [AW-1:0]      load_idx_q;
  logic [VcntW-1:0]   vcnt_q;
  logic [ToW-1:0]     to_cnt_q;
  logic               ready_q, ready_seen_q, reload_pend_q;
  logic [D_WIDTH-1:0] angle_q, curr_a_q, curr_b_q, curr_c_q, curr_t_q;
  logic [D_WIDTH-1:0] addr_q, d_data_q, q_data_q;
  logic               valid_q, d_wen_q, q_wen_q, err_q;
  logic [15:0]        overrun_q, samples_q;
  logic               tick, rise, issue_done, outstanding;

  assign busy        = (state_q != StIdle);
  assign rise        = core_ready && !ready_q;
  assign issue_done  = (vcnt_q == VcntLast) && (ready_seen_q || rise);
  assign outstanding = (state_q == StIssue) || (state_q == StWaitReady);

  foc_tick_gen #(
    .TICK_W(TICK_W)
  ) u_tick (
    .clk     (clk),
    .rstb    (rstb),
    .busy_i  (busy),
    .period_i(tick_period),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < int'(Entries); i++) begin
        dtab_q[i] <= '0;
        qtab_q[i] <= '0;
      end
    end else if (cfg_wen) begin
      if (cfg_axis) begin
        qtab_q[cfg_addr] <= cfg_data;
      end else begin
        dtab_q[cfg_addr] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= StIdle;
      load_idx_q    <= '0;
      vcnt_q        <= '0;
      to_cnt_q      <= '0;
      ready_q       <= 1'b0;
      ready_seen_q  <= 1'b0;
      reload_pend_q <= 1'b1;
      angle_q       <= '0;
      curr_a_q      <= '0;
      curr_b_q      <= '0;
      curr_c_q      <= '0;
      curr_t_q      <= '0;
      addr_q        <= '0;
      d_data_q      <= '0;
      q_data_q      <= '0;
      valid_q       <= 1'b0;
      d_wen_q       <= 1'b0;
      q_wen_q       <= 1'b0;
      err_q         <= 1'b0;
      overrun_q     <= '0;
      samples_q     <= '0;
    end else begin
      ready_q <= core_ready;
      d_wen_q <= 1'b0;
      q_wen_q <= 1'b0;
      if (cfg_wen) begin
        reload_pend_q <= 1'b1;
      end
      // A tick while a sample is outstanding is dropped, not queued.
      if (tick && outstanding && (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end
      case (state_q)
        StIdle, StWaitTick: begin
          if ((state_q == StIdle && enable) || (tick && reload_pend_q)) begin
            state_q    <= StLoad;
            load_idx_q <= '0;
            d_wen_q    <= 1'b1;
            q_wen_q    <= 1'b1;
            addr_q     <= '0;
            d_data_q   <= dtab_q[0];
            q_data_q   <= qtab_q[0];
          end else if (state_q == StWaitTick && tick && !enable) begin
            state_q <= StIdle;
          end else if (state_q == StWaitTick && tick) begin
            state_q      <= StIssue;
            angle_q      <= angle_in;
            curr_a_q     <= currA_in;
            curr_b_q     <= currB_in;
            curr_c_q     <= currC_in;
            curr_t_q     <= currT_in;
            valid_q      <= 1'b1;
            vcnt_q       <= '0;
            to_cnt_q     <= '0;
            ready_seen_q <= 1'b0;
          end
        end
        StLoad: begin
          if (load_idx_q == LoadLast) begin
            state_q <= StWaitTick;
            if (!cfg_wen) begin
              reload_pend_q <= 1'b0;
            end
          end else begin
            load_idx_q <= load_idx_q + AW'(1);
            d_wen_q    <= 1'b1;
            q_wen_q    <= 1'b1;
            addr_q     <= D_WIDTH'(load_idx_q + AW'(1));
            d_data_q   <= dtab_q[load_idx_q + AW'(1)];
            q_data_q   <= qtab_q[load_idx_q + AW'(1)];
          end
        end
        StIssue: begin
          to_cnt_q <= to_cnt_q + ToW'(1);
          if (rise) begin
            ready_seen_q <= 1'b1;
          end
          if (issue_done) begin
            valid_q   <= 1'b0;
            samples_q <= samples_q + 16'd1;
            state_q   <= StWaitTick;
          end else if (to_cnt_q == ToLast) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StError;
          end else if (vcnt_q == VcntLast) begin
            valid_q <= 1'b0;
            state_q <= StWaitReady;
          end else begin
            vcnt_q <= vcnt_q + VcntW'(1);
          end
        end
        StWaitReady: begin
          to_cnt_q <= to_cnt_q + ToW'(1);
          if (rise) begin
            samples_q <= samples_q + 16'd1;
            state_q   <= StWaitTick;
          end else if (to_cnt_q == ToLast) begin
            err_q   <= 1'b1;
            state_q <= StError;
          end
        end
        StError: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign angle_out   = angle_q;
  assign currA_out   = curr_a_q;
  assign currB_out   = curr_b_q;
  assign currC_out   = curr_c_q;
  assign currT_out   = curr_t_q;
  assign core_valid  = valid_q;
  assign pid_d_wen   = d_wen_q;
  assign pid_q_wen   = q_wen_q;
  assign pid_d_addr  = addr_q;
  assign pid_q_addr  = addr_q;
  assign pid_d_data  = d_data_q;
  assign pid_q_data  = q_data_q;
  assign err_timeout = err_q;
  assign overrun_cnt = overrun_q;
  assign sample_cnt  = samples_q;

endmodule
